sobel_stream_ctrl: RTL and testbench

SOBEL_STREAM_CTRL -- requirements
Module: sobel_stream_ctrl

---
 rtl/sobel_stream_ctrl.sv | 173 +++++++++++++++++
 tb/tb_sobel_stream_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream_ctrl.sv
// Streaming 3x3 Sobel magnitude over a raster-order frame, using two rotating line buffers.
// Optional output-stall counter enabled by defining SOBEL_STREAM_CTRL_PERF_EN.

module sobel_kernel (
  input  logic [7:0] p11, input logic [7:0] p12, input logic [7:0] p13,
  input  logic [7:0] p21, input logic [7:0] p22, input logic [7:0] p23,
  input  logic [7:0] p31, input logic [7:0] p32, input logic [7:0] p33,
  output logic [7:0] mag
);
  logic [10:0] gx_pos, gx_neg, gy_pos, gy_neg, ax, ay, sum;

  // Magnitude is (|Gx| + |Gy|) / 8; max 2040 fits 11 bits so no saturation is needed.
  always_comb begin
    gx_pos = {3'b000, p13} + {2'b00, p23, 1'b0} + {3'b000, p33};
    gx_neg = {3'b000, p11} + {2'b00, p21, 1'b0} + {3'b000, p31};
    gy_pos = {3'b000, p31} + {2'b00, p32, 1'b0} + {3'b000, p33};
    gy_neg = {3'b000, p11} + {2'b00, p12, 1'b0} + {3'b000, p13};
    ax     = (gx_pos >= gx_neg) ? (gx_pos - gx_neg) : (gx_neg - gx_pos);
    ay     = (gy_pos >= gy_neg) ? (gy_pos - gy_neg) : (gy_neg - gy_pos);
    sum    = ax + ay;
  end

  assign mag = 8'(sum >> 3);
  // p22 carries no weight in either gradient.
  logic unused_p22;
  assign unused_p22 = ^p22;
endmodule

module sobel_stream_ctrl #(
  parameter int IMG_W = 352,
  parameter int IMG_H = 288
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] stall_cycles,
  output logic [1:0]  dbg_state
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t         state_q;
  logic [CW-1:0]  col_q;
  logic [RW-1:0]  row_q;
  logic           sel_q;
  logic           out_valid_q, busy_q, done_q;
  logic [7:0]     out_data_q;
  logic [23:0]    wl_q, wm_q;
  logic [7:0]     lb0 [IMG_W];
  logic [7:0]     lb1 [IMG_W];
  logic [7:0]     up1, up2, kmag;
  logic           accept, emit, last_col, last_row;

  // Handshake: a beat transfers on a rising edge where valid and ready are both high;
  // in_ready is granted only in RUN when the output register is empty or being drained.
  assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign last_col = (col_q == CW'(IMG_W - 1));
  assign last_row = (row_q == RW'(IMG_H - 1));
  assign emit     = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

  // sel_q picks which buffer holds row r-1; the other holds r-2 and is overwritten in place.
  assign up1 = sel_q ? lb1[col_q] : lb0[col_q];
  assign up2 = sel_q ? lb0[col_q] : lb1[col_q];

  sobel_kernel u_kernel (
    .p11(wl_q[23:16]), .p12(wm_q[23:16]), .p13(up2),
    .p21(wl_q[15:8]),  .p22(wm_q[15:8]),  .p23(up1),
    .p31(wl_q[7:0]),   .p32(wm_q[7:0]),   .p33(in_data),
    .mag(kmag)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      if (sel_q) lb0[col_q] <= in_data;
      else       lb1[col_q] <= in_data;
      wl_q <= wm_q;
      wm_q <= {up2, up1, in_data};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      sel_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            col_q   <= '0;
            row_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            if (last_col) begin
              col_q <= '0;
              sel_q <= ~sel_q;
              if (last_row) begin
                row_q   <= '0;
                state_q <= DRAIN;
              end else begin
                row_q <= row_q + RW'(1);
              end
            end else begin
              col_q <= col_q + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (!out_valid_q || out_ready) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase

      if (emit) begin
        out_valid_q <= 1'b1;
        out_data_q  <= kmag;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

`ifdef SOBEL_STREAM_CTRL_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (state_q == IDLE && start) begin
      stall_q <= '0;
    end else if (busy_q && out_valid_q && !out_ready && stall_q != '1) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// Bench for sobel_stream_ctrl: a 4x4 instance for directed frames and a 16x12 instance for a random frame.
module tb_sobel_stream_ctrl;
  localparam int SW = 4;
  localparam int SH = 4;
  localparam int BW = 16;
  localparam int BH = 12;

  logic clk = 1'b0;
  logic reset_n;

  logic        start_s, in_valid_s, in_ready_s, out_valid_s, out_ready_s, busy_s, done_s;
  logic [7:0]  in_data_s, out_data_s;
  logic [31:0] stall_s;
  logic [1:0]  state_s;

  logic        start_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b, done_b;
  logic [7:0]  in_data_b, out_data_b;
  logic [31:0] stall_b;
  logic [1:0]  state_b;

  logic [7:0] exp_q[$];
  logic [7:0] exp_big_q[$];
  logic [7:0] frame_s [0:SW*SH-1];
  logic [7:0] frame_b [0:BW*BH-1];

  int checks = 0;
  int failures = 0;
  int out_cnt_s = 0;
  int done_cnt_s = 0;
  int out_cnt_b = 0;
  int done_cnt_b = 0;

  always #5 clk = ~clk;

  sobel_stream_ctrl #(.IMG_W(SW), .IMG_H(SH)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start_s), .in_valid(in_valid_s), .in_data(in_data_s),
    .in_ready(in_ready_s), .out_valid(out_valid_s), .out_data(out_data_s), .out_ready(out_ready_s),
    .busy(busy_s), .done(done_s), .stall_cycles(stall_s), .dbg_state(state_s)
  );

  sobel_stream_ctrl #(.IMG_W(BW), .IMG_H(BH)) u_big (
    .clk(clk), .reset_n(reset_n), .start(start_b), .in_valid(in_valid_b), .in_data(in_data_b),
    .in_ready(in_ready_b), .out_valid(out_valid_b), .out_data(out_data_b), .out_ready(out_ready_b),
    .busy(busy_b), .done(done_b), .stall_cycles(stall_b), .dbg_state(state_b)
  );

  // Scoreboards: pop one expected value per consumed output.
  always @(negedge clk) begin
    if (reset_n && out_valid_s && out_ready_s) begin
      logic [7:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL small_unexpected_out got=%0d required=none", out_data_s);
      end else begin
        e = exp_q.pop_front();
        if (out_data_s !== e) begin
          failures++;
          $display("FAIL small_out_data #%0d got=%0d required=%0d", out_cnt_s, out_data_s, e);
        end
      end
      out_cnt_s++;
    end
    if (reset_n && done_s) done_cnt_s++;
  end

  always @(negedge clk) begin
    if (reset_n && out_valid_b && out_ready_b) begin
      logic [7:0] e;
      checks++;
      if (exp_big_q.size() == 0) begin
        failures++;
        $display("FAIL big_unexpected_out got=%0d required=none", out_data_b);
      end else begin
        e = exp_big_q.pop_front();
        if (out_data_b !== e) begin
          failures++;
          $display("FAIL big_out_data #%0d got=%0d required=%0d", out_cnt_b, out_data_b, e);
        end
      end
      out_cnt_b++;
    end
    if (reset_n && done_b) done_cnt_b++;
  end

  function automatic logic [7:0] sobel_ref(input int p11, p12, p13, p21, p23, p31, p32, p33);
    int gx, gy;
    gx = (p13 + 2 * p23 + p33) - (p11 + 2 * p21 + p31);
    gy = (p31 + 2 * p32 + p33) - (p11 + 2 * p12 + p13);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    return 8'((gx + gy) / 8);
  endfunction

  function automatic int fs(input int r, input int c);
    return int'(frame_s[r * SW + c]);
  endfunction

  function automatic int fb(input int r, input int c);
    return int'(frame_b[r * BW + c]);
  endfunction

  task automatic push_model_s();
    for (int r = 1; r < SH - 1; r++)
      for (int c = 1; c < SW - 1; c++)
        exp_q.push_back(sobel_ref(fs(r-1,c-1), fs(r-1,c), fs(r-1,c+1), fs(r,c-1), fs(r,c+1),
                                  fs(r+1,c-1), fs(r+1,c), fs(r+1,c+1)));
  endtask

  task automatic run_frame_s(input int stall_idx, input int stall_len, input int start_idx);
    int r, c, budget;
    bit acc, seen;
    out_cnt_s = 0;
    done_cnt_s = 0;
    @(posedge clk); #1;
    start_s = 1'b1;
    out_ready_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    checks++;
    if (state_s !== 2'd1 || busy_s !== 1'b1) begin
      failures++;
      $display("FAIL enter_run state=%0d busy=%0b required state=1 busy=1", state_s, busy_s);
    end
    for (int idx = 0; idx < SW * SH; idx++) begin
      r = idx / SW;
      c = idx % SW;
      in_valid_s = 1'b1;
      in_data_s = frame_s[idx];
      if (idx == start_idx) start_s = 1'b1;
      acc = 1'b0;
      budget = 0;
      while (!acc && budget < 50) begin
        @(negedge clk);
        acc = in_ready_s;
        @(posedge clk); #1;
        start_s = 1'b0;
        budget++;
      end
      checks++;
      if (!acc) begin
        failures++;
        $display("FAIL accept_timeout pixel=%0d got=no_accept required=accept", idx);
        in_valid_s = 1'b0;
        return;
      end
      checks++;
      if (out_valid_s !== ((r >= 2 && c >= 2) ? 1'b1 : 1'b0)) begin
        failures++;
        $display("FAIL out_valid_after_pixel (%0d,%0d) got=%0b required=%0b", r, c, out_valid_s, (r >= 2 && c >= 2));
      end
      checks++;
      if (state_s !== ((idx == SW * SH - 1) ? 2'd2 : 2'd1)) begin
        failures++;
        $display("FAIL state_after_pixel %0d got=%0d required=%0d", idx, state_s, (idx == SW * SH - 1) ? 2 : 1);
      end
      if (idx == stall_idx) begin
        out_ready_s = 1'b0;
        in_valid_s = 1'b1;
        in_data_s = frame_s[idx + 1];
        for (int k = 0; k < stall_len; k++) begin
          @(negedge clk);
          checks++;
          if (in_ready_s !== 1'b0 || out_valid_s !== 1'b1) begin
            failures++;
            $display("FAIL stall_handshake cyc=%0d in_ready=%0b out_valid=%0b required 0/1", k, in_ready_s, out_valid_s);
          end
          if (exp_q.size() > 0) begin
            checks++;
            if (out_data_s !== exp_q[0]) begin
              failures++;
              $display("FAIL stall_hold_data cyc=%0d got=%0d required=%0d", k, out_data_s, exp_q[0]);
            end
          end
          @(posedge clk); #1;
        end
        out_ready_s = 1'b1;
      end
    end
    in_valid_s = 1'b0;
    seen = 1'b0;
    budget = 0;
    while (!seen && budget < 20) begin
      @(negedge clk);
      seen = done_s;
      budget++;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL done_timeout got=no_done required=done");
    end
    @(negedge clk);
    checks++;
    if (done_s !== 1'b0 || busy_s !== 1'b0 || state_s !== 2'd0) begin
      failures++;
      $display("FAIL after_done done=%0b busy=%0b state=%0d required 0/0/0", done_s, busy_s, state_s);
    end
    checks++;
    if (out_cnt_s != (SW - 2) * (SH - 2) || done_cnt_s != 1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL frame_counts outputs=%0d dones=%0d left=%0d required 4/1/0", out_cnt_s, done_cnt_s, exp_q.size());
    end
    checks++;
`ifdef SOBEL_STREAM_CTRL_PERF_EN
    if (stall_s !== 32'(stall_len)) begin
      failures++;
      $display("FAIL stall_cycles got=%0d required=%0d", stall_s, stall_len);
    end
`else
    if (stall_s !== 32'd0) begin
      failures++;
      $display("FAIL stall_cycles got=%0d required=0", stall_s);
    end
`endif
  endtask

  task automatic load_edge();
    for (int i = 0; i < SW * SH; i++) frame_s[i] = ((i % SW) >= 2) ? 8'd255 : 8'd0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start_s = 0; in_valid_s = 0; in_data_s = 0; out_ready_s = 1;
    start_b = 0; in_valid_b = 0; in_data_b = 0; out_ready_b = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (state_s !== 2'd0 || busy_s !== 1'b0 || done_s !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl state=%0d busy=%0b done=%0b required 0/0/0", state_s, busy_s, done_s);
    end
    checks++;
    if (out_valid_s !== 1'b0 || out_data_s !== 8'd0 || in_ready_s !== 1'b0) begin
      failures++;
      $display("FAIL reset_data out_valid=%0b out_data=%0d in_ready=%0b required 0/0/0", out_valid_s, out_data_s, in_ready_s);
    end
    checks++;
    if (stall_s !== 32'd0) begin
      failures++;
      $display("FAIL reset_stall got=%0d required=0", stall_s);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_flat();
    for (int i = 0; i < SW * SH; i++) frame_s[i] = 8'd100;
    repeat (4) exp_q.push_back(8'd0);
    run_frame_s(-1, 0, -1);
  endtask

  task automatic test_vertical_edge();
    load_edge();
    repeat (4) exp_q.push_back(8'd127);
    run_frame_s(-1, 0, -1);
  endtask

  task automatic test_backpressure();
    load_edge();
    repeat (4) exp_q.push_back(8'd127);
    run_frame_s(10, 6, -1);
  endtask

  task automatic test_start_ignored();
    load_edge();
    repeat (4) exp_q.push_back(8'd127);
    run_frame_s(-1, 0, 5);
  endtask

  task automatic test_reset_mid_frame();
    int n, budget;
    load_edge();
    @(posedge clk); #1;
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    n = 0;
    budget = 0;
    while (n < 7 && budget < 50) begin
      in_valid_s = 1'b1;
      in_data_s = frame_s[n];
      @(negedge clk);
      if (in_ready_s) n++;
      @(posedge clk); #1;
      budget++;
    end
    in_valid_s = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (state_s !== 2'd0 || out_valid_s !== 1'b0 || busy_s !== 1'b0 || in_ready_s !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset state=%0d out_valid=%0b busy=%0b in_ready=%0b required 0/0/0/0",
               state_s, out_valid_s, busy_s, in_ready_s);
    end
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_random_small();
    for (int i = 0; i < SW * SH; i++) frame_s[i] = 8'($urandom_range(0, 255));
    push_model_s();
    run_frame_s(-1, 0, -1);
  endtask

  task automatic test_big_random();
    int idx, budget;
    bit acc, seen;
    for (int i = 0; i < BW * BH; i++) frame_b[i] = 8'($urandom_range(0, 255));
    for (int r = 1; r < BH - 1; r++)
      for (int c = 1; c < BW - 1; c++)
        exp_big_q.push_back(sobel_ref(fb(r-1,c-1), fb(r-1,c), fb(r-1,c+1), fb(r,c-1), fb(r,c+1),
                                      fb(r+1,c-1), fb(r+1,c), fb(r+1,c+1)));
    out_cnt_b = 0;
    done_cnt_b = 0;
    @(posedge clk); #1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    idx = 0;
    budget = 0;
    while (idx < BW * BH && budget < 20000) begin
      out_ready_b = ($urandom_range(0, 3) != 0);
      in_valid_b = ($urandom_range(0, 3) != 0);
      in_data_b = frame_b[idx];
      @(negedge clk);
      acc = in_valid_b && in_ready_b;
      @(posedge clk); #1;
      if (acc) idx++;
      budget++;
    end
    in_valid_b = 1'b0;
    checks++;
    if (idx != BW * BH) begin
      failures++;
      $display("FAIL big_feed_timeout accepted=%0d required=%0d", idx, BW * BH);
    end
    seen = 1'b0;
    budget = 0;
    while (!seen && budget < 200) begin
      out_ready_b = ($urandom_range(0, 1) != 0);
      @(negedge clk);
      seen = done_b;
      @(posedge clk); #1;
      budget++;
    end
    out_ready_b = 1'b1;
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL big_done_timeout got=no_done required=done");
    end
    repeat (2) @(negedge clk);
    checks++;
    if (out_cnt_b != (BW - 2) * (BH - 2) || done_cnt_b != 1 || exp_big_q.size() != 0) begin
      failures++;
      $display("FAIL big_counts outputs=%0d dones=%0d left=%0d required %0d/1/0",
               out_cnt_b, done_cnt_b, exp_big_q.size(), (BW - 2) * (BH - 2));
    end
  endtask

  initial begin
    test_reset();
    test_flat();
    test_vertical_edge();
    test_backpressure();
    test_start_ignored();
    test_reset_mid_frame();
    test_random_small();
    test_big_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
